// File: rtl/corr_pkg.sv
// Shared constants and state encoding for the per-lag correlator accumulator.
package corr_pkg;

    localparam int unsigned NLAG   = 256;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned LAG_W  = $clog2(NLAG);

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/corr_acc_ram.sv
// Per-lag accumulator storage: pipeline read + write on port A, host read on port B.
module corr_acc_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    a_raddr,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             a_we,
    input  logic [AW-1:0]    a_waddr,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic             b_re,
    input  logic [AW-1:0]    b_raddr,
    output logic [WIDTH-1:0] b_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] a_rdata_q;
    logic [WIDTH-1:0] b_rdata_q;

    // Pipeline port: write plus read of an older address; reads return old data.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem_q[a_waddr] <= a_wdata;
        end
        a_rdata_q <= mem_q[a_raddr];
    end

    // Host port output register; cleared by reset so rd_data reads 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_rdata_q <= '0;
        end else if (b_re) begin
            b_rdata_q <= mem_q[b_raddr];
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/corr_accum256.sv
// Per-lag multiply-accumulate stage: acc[k] += x_cur * x_lag[k] over each burst.
module corr_accum256
    import corr_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    x_cur,
    input  logic [DATA_W-1:0]    x_lag,
    input  logic                 sync_in,
    input  logic                 clr,
    input  logic                 rd_en,
    input  logic [LAG_W-1:0]     rd_addr,
    output logic [ACC_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 clr_done,
    output logic [31:0]          frame_cnt,
    output logic                 overrun,
    output logic                 sat
);

    localparam int unsigned PROD_W          = 2 * DATA_W;
    localparam logic [LAG_W-1:0] LAG_LAST   = LAG_W'(NLAG - 1);
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(ACC_MAX);

    state_e                 state_q, state_d;
    logic [LAG_W-1:0]       k_q, k_d;
    logic [DATA_W-1:0]      xc_q, xc_d;
    logic                   clr_pend_q, clr_pend_d;
    logic                   v1_q, v1_d;
    logic [LAG_W-1:0]       k1_q, k1_d;
    logic [DATA_W-1:0]      xl1_q, xl1_d;
    logic                   v2_q, v2_d;
    logic [LAG_W-1:0]       k2_q, k2_d;
    logic [PROD_W-1:0]      p2_q, p2_d;
    logic [ACC_WIDTH-1:0]   rd2_q, rd2_d;
    logic                   busy_q, busy_d;
    logic                   burst_done_q, burst_done_d;
    logic                   clr_done_q, clr_done_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;
    logic                   overrun_q, overrun_d;
    logic                   sat_q, sat_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   pipe_empty;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   sum_sat;
    logic [ACC_WIDTH-1:0]   ram_rdata;
    logic                   ram_we;
    logic [LAG_W-1:0]       ram_waddr;
    logic [ACC_WIDTH-1:0]   ram_wdata;

    // S2 saturating add of the zero-extended product onto the old accumulator.
    always_comb begin
        sum     = {1'b0, rd2_q} + {{(ACC_WIDTH + 1 - PROD_W){1'b0}}, p2_q};
        sum_sat = sum[ACC_WIDTH] ? SAT_MAX : sum[ACC_WIDTH-1:0];
    end

    // RAM write: pipeline S2 during bursts, zero sweep during CLEAR.
    assign ram_we    = v2_q || (state_q == CLEAR);
    assign ram_waddr = v2_q ? k2_q : k_q;
    assign ram_wdata = v2_q ? sum_sat : '0;

    // Sequencer, pipeline advance and status bookkeeping.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        xc_d         = xc_q;
        clr_pend_d   = clr_pend_q;
        v1_d         = 1'b0;
        k1_d         = k_q;
        xl1_d        = x_lag;
        v2_d         = v1_q;
        k2_d         = k1_q;
        p2_d         = PROD_W'(xc_q) * PROD_W'(xl1_q);
        rd2_d        = ram_rdata;
        burst_done_d = 1'b0;
        clr_done_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;
        sat_d        = sat_q;
        rd_valid_d   = rd_en;
        pipe_empty   = !v1_q && !v2_q;

        if (clr && state_q != CLEAR) begin
            clr_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (sync_in) begin
                    xc_d    = x_cur;
                    v1_d    = 1'b1;
                    k_d     = k_q + LAG_W'(1);
                    state_d = ACC;
                end else if ((clr || clr_pend_q) && pipe_empty) begin
                    clr_pend_d = 1'b0;
                    state_d    = CLEAR;
                end
            end
            ACC: begin
                v1_d = 1'b1;
                k_d  = k_q + LAG_W'(1);
                if (sync_in) begin
                    overrun_d = 1'b1;
                end
                if (k_q == LAG_LAST) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                k_d = k_q + LAG_W'(1);
                if (sync_in) begin
                    overrun_d = 1'b1;
                end
                if (k_q == LAG_LAST) begin
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (v2_q) begin
            if (sum[ACC_WIDTH]) begin
                sat_d = 1'b1;
            end
            if (k2_q == LAG_LAST) begin
                burst_done_d = 1'b1;
                frame_cnt_d  = frame_cnt_q + 32'd1;
            end
        end

        if (clr_done_d) begin
            frame_cnt_d = '0;
            overrun_d   = 1'b0;
            sat_d       = 1'b0;
        end

        busy_d = (state_d != IDLE) || v1_d || v2_d || burst_done_d;
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            xc_q         <= '0;
            clr_pend_q   <= 1'b0;
            v1_q         <= 1'b0;
            k1_q         <= '0;
            xl1_q        <= '0;
            v2_q         <= 1'b0;
            k2_q         <= '0;
            p2_q         <= '0;
            rd2_q        <= '0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            clr_done_q   <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            sat_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            xc_q         <= xc_d;
            clr_pend_q   <= clr_pend_d;
            v1_q         <= v1_d;
            k1_q         <= k1_d;
            xl1_q        <= xl1_d;
            v2_q         <= v2_d;
            k2_q         <= k2_d;
            p2_q         <= p2_d;
            rd2_q        <= rd2_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            clr_done_q   <= clr_done_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            sat_q        <= sat_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    corr_acc_ram #(
        .DEPTH (NLAG),
        .WIDTH (ACC_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_raddr (k_q),
        .a_rdata (ram_rdata),
        .a_we    (ram_we),
        .a_waddr (ram_waddr),
        .a_wdata (ram_wdata),
        .b_re    (rd_en),
        .b_raddr (rd_addr),
        .b_rdata (rd_data)
    );

    assign rd_valid   = rd_valid_q;
    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign clr_done   = clr_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_corr_accum256.sv
// Bench for corr_accum256: a 32-bit and a 16-bit accumulator instance share stimulus.
module tb_corr_accum256;
    import corr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  x_cur = '0, x_lag = '0, rd_addr = '0;
    logic        sync_in = 1'b0, clr = 1'b0, rd_en = 1'b0;

    logic [31:0] rd_data_a, frame_cnt_a;
    logic        rd_valid_a, busy_a, burst_done_a, clr_done_a, overrun_a, sat_a;
    logic [15:0] rd_data_b;
    logic [31:0] frame_cnt_b;
    logic        rd_valid_b, busy_b, burst_done_b, clr_done_b, overrun_b, sat_b;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     last_s = 0;
    int     lag_v [NLAG];
    longint m_a [NLAG];
    longint m_b [NLAG];
    bit     sat_ae = 0, sat_be = 0, ovr_e = 0;
    int     fcnt_e = 0;

    corr_accum256 u_dut (
        .clk(clk), .rst_n(rst_n), .x_cur(x_cur), .x_lag(x_lag), .sync_in(sync_in),
        .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .busy(busy_a), .burst_done(burst_done_a),
        .clr_done(clr_done_a), .frame_cnt(frame_cnt_a), .overrun(overrun_a), .sat(sat_a)
    );

    corr_accum256 #(.ACC_WIDTH(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .x_cur(x_cur), .x_lag(x_lag), .sync_in(sync_in),
        .clr(clr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .busy(busy_b), .burst_done(burst_done_b),
        .clr_done(clr_done_b), .frame_cnt(frame_cnt_b), .overrun(overrun_b), .sat(sat_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: each lag sums xc*lag with saturation at the accumulator width.
    task automatic model_burst(input int xc, input int nk);
        for (int k = 0; k < nk; k++) begin
            longint p = longint'(xc) * longint'(lag_v[k]);
            m_a[k] = m_a[k] + p;
            if (m_a[k] > 64'hFFFF_FFFF) begin m_a[k] = 64'hFFFF_FFFF; sat_ae = 1; end
            m_b[k] = m_b[k] + p;
            if (m_b[k] > 65535) begin m_b[k] = 65535; sat_be = 1; end
        end
        if (nk == NLAG) fcnt_e++;
    endtask

    task automatic model_clear;
        for (int k = 0; k < NLAG; k++) begin m_a[k] = 0; m_b[k] = 0; end
        fcnt_e = 0; ovr_e = 0; sat_ae = 0; sat_be = 0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "/frame_a"}, frame_cnt_a, fcnt_e);
        check({tag, "/frame_b"}, frame_cnt_b, fcnt_e);
        check({tag, "/ovr_a"}, overrun_a, ovr_e);
        check({tag, "/ovr_b"}, overrun_b, ovr_e);
        check({tag, "/sat_a"}, sat_a, sat_ae);
        check({tag, "/sat_b"}, sat_b, sat_be);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/busy"}, {busy_a, busy_b}, 0);
        check({tag, "/bdone"}, {burst_done_a, burst_done_b}, 0);
        check({tag, "/cdone"}, {clr_done_a, clr_done_b}, 0);
        check({tag, "/frame"}, {frame_cnt_a, frame_cnt_b}, 0);
        check({tag, "/flags"}, {overrun_a, overrun_b, sat_a, sat_b}, 0);
        check({tag, "/rd"}, {rd_valid_a, rd_valid_b, rd_data_a, rd_data_b}, 0);
    endtask

    task automatic wait_clr(input int exp_cyc);
        int at = -1;
        for (int i = 0; i < 700; i++) begin
            if (clr_done_a) begin at = cyc; break; end
            tick;
        end
        check("clr_done_at", at, exp_cyc);
        check("clr_done_b", clr_done_b, 1);
        model_clear;
        check_status("clr");
    endtask

    task automatic do_clear;
        int c;
        c = cyc;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        wait_clr(c + NLAG + 1);
    endtask

    // One burst; optional stray sync, mid-burst clr, or reset at a given lag.
    task automatic do_burst(input int xc, input int inj, input int clr_at, input int rst_at);
        int s;
        s = cyc;
        last_s = s;
        sync_in = 1'b1; x_cur = 8'(xc); x_lag = 8'(lag_v[0]);
        for (int k = 1; k < NLAG; k++) begin
            tick;
            sync_in = (k == inj);
            clr = (k == clr_at);
            x_cur = 8'($urandom);
            x_lag = 8'(lag_v[k]);
            if (k == 1) check("busy_start", busy_a, 1);
            if (k == rst_at) begin
                rst_n = 1'b0; sync_in = 1'b0; clr = 1'b0;
                #1;
                check_reset("rst_mid");
                model_burst(xc, k - 2);
                fcnt_e = 0; ovr_e = 0; sat_ae = 0; sat_be = 0;
                tick; tick;
                rst_n = 1'b1;
                tick;
                return;
            end
        end
        tick;
        sync_in = 1'b0; clr = 1'b0; x_lag = 8'($urandom);
        tick;
        check("bd_early", burst_done_a, 0);
        tick;
        check("bd_at_a", burst_done_a, 1);
        check("bd_at_b", burst_done_b, 1);
        check("busy_end", busy_a, 1);
        model_burst(xc, NLAG);
        if (inj >= 0) ovr_e = 1;
        check_status("burst");
    endtask

    task automatic read_all(input string tag);
        rd_en = 1'b1;
        for (int a = 0; a < NLAG; a++) begin
            rd_addr = 8'(a);
            tick;
            check($sformatf("%s/rv[%0d]", tag, a), rd_valid_a, 1);
            check($sformatf("%s/acc32[%0d]", tag, a), rd_data_a, m_a[a]);
            check($sformatf("%s/acc16[%0d]", tag, a), rd_data_b, m_b[a]);
        end
        rd_en = 1'b0;
        tick;
        check({tag, "/rv_off"}, rd_valid_a, 0);
    endtask

    task automatic fill_rand;
        for (int k = 0; k < NLAG; k++) lag_v[k] = int'($urandom_range(0, 255));
    endtask

    initial begin
        for (int k = 0; k < NLAG; k++) begin m_a[k] = 0; m_b[k] = 0; end
        repeat (3) tick;
        check_reset("por");
        rst_n = 1'b1;
        tick;
        do_clear;

        for (int k = 0; k < NLAG; k++) lag_v[k] = 2;
        do_burst(3, -1, -1, -1);
        read_all("const");

        do_clear;
        for (int k = 0; k < NLAG; k++) lag_v[k] = k;
        repeat (3) do_burst(1, -1, -1, -1);
        read_all("ramp");

        do_clear;
        for (int k = 0; k < NLAG; k++) lag_v[k] = 255;
        repeat (2) do_burst(255, -1, -1, -1);
        read_all("sat");

        do_clear;
        fill_rand;
        do_burst(int'($urandom_range(0, 255)), 100, -1, -1);
        read_all("ovr");
        do_clear;

        fill_rand;
        do_burst(int'($urandom_range(0, 255)), -1, 120, -1);
        wait_clr(last_s + NLAG + 2 + NLAG + 1);
        read_all("clrmid");

        repeat (2) begin
            fill_rand;
            do_burst(int'($urandom_range(0, 255)), -1, -1, -1);
        end
        read_all("rand");

        fill_rand;
        do_burst(int'($urandom_range(1, 255)), -1, -1, 50);
        read_all("rstmid");
        do_clear;
        fill_rand;
        do_burst(int'($urandom_range(0, 255)), -1, -1, -1);
        read_all("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/corr_accum256.md
# corr_accum256

Per-lag multiply-accumulate stage of the correlator, fed directly by the 8-bit, 256-word shift-RAM delay line. For every new input sample the delay line emits a burst of 256 lagged samples. This block multiplies each lagged sample by the current sample and accumulates the product into a per-lag accumulator RAM, building the autocorrelation sum acc[k] = Σ x[n]·x[n−k]. A second, synchronous port lets the host read accumulators. A sweep clears them.

## Interface
- NLAG, 256, number of lags per burst (power of two); address width LAG_W = log2(NLAG)
- DATA_W, 8, width of sample inputs
- ACC_W, 32, accumulator width (≥ 2·DATA_W)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; clock clk
- x_cur  in  DATA_W  current sample (delay line dout); sampled only in the sync_in cycle
- x_lag  in  DATA_W  lagged sample stream (delay line dshift)
- sync_in  in  1  one-cycle pulse (delay line sout); marks lag 0 on x_lag
- clr  in  1  one-cycle request to zero all accumulators
- rd_en  in  1  host read strobe
- rd_addr  in  LAG_W  host read lag index
- rd_data  out  ACC_W  accumulator value, valid the cycle after rd_en
- rd_valid  out  1  high with rd_data
- busy  out  1  high outside IDLE or while the pipeline is non-empty
- burst_done  out  1  one-cycle pulse after the last write of a burst
- clr_done  out  1  one-cycle pulse after the last clear write
- frame_cnt  out  32  completed bursts since the last clear; wraps
- overrun  out  1  sticky; a sync_in was dropped
- sat  out  1  sticky; an accumulator saturated

## Operation
- States: IDLE, ACC, CLEAR. A lag counter k (LAG_W bits) counts lags.
- IDLE + sync_in: latch x_cur into xc. Lag 0 is x_lag in this same cycle. Go to ACC with k=1; that cycle's sample is handled as k=0.
- ACC: accept one x_lag per cycle, k incrementing. After the sample with k=NLAG−1, return to IDLE. The counter wraps to 0.
- 3-stage pipeline per lag:
  - S0: register x_lag and k, and issue the RAM read of acc[k].
  - S1: form the unsigned product p = xc·x_lag (2·DATA_W bits).
  - S2: zero-extend p to ACC_W, do a saturating add with the read data, and write acc[k].
- Saturation: if the sum exceeds 2^ACC_W−1, write 2^ACC_W−1 and set sat.
- Hazard: addresses are strictly increasing inside a burst. The next burst needs at least 2 idle cycles, so there is no read-after-write collision. No forwarding path is required.
- clr accepted in IDLE with an empty pipeline: go to CLEAR and write 0 to addresses 0..NLAG−1, one per cycle. Then pulse clr_done, zero frame_cnt, clear overrun and sat, and return to IDLE.
- clr arriving during ACC or while the pipeline is draining: latch it as pending and execute it as soon as the condition above holds.
- sync_in in ACC or CLEAR: ignore it and set overrun. Accumulators are unaffected by the dropped burst.
- sync_in and clr both pending in IDLE: sync_in wins; the clear stays pending.
- Host port: rd_data = acc[rd_addr] in the cycle after rd_en. Reads are allowed in any state; a lag being updated in flight returns its pre-update value.
- RAM content is initialised to zero at configuration. rst_n does not clear the RAM.

## Timing
- Reset: every output is 0; state is IDLE; pipeline valid bits are cleared; any pending clr is dropped.
- Reset mid-burst or mid-clear: abort immediately; no further RAM writes. RAM content becomes partially updated, and a clr is required.
- sync_in at cycle s: acc[k] is written at the edge ending cycle s+k+2. burst_done is high in cycle s+NLAG+2, and frame_cnt increments with it. busy is high from s+1 through s+NLAG+2.
- Clear accepted at cycle c: the writes occupy c+1..c+NLAG, and clr_done is high in cycle c+NLAG+1.
- Minimum sync_in spacing for loss-free operation: NLAG+2 cycles. The delay line's sequencing guarantees this.

## Structure
- Package corr_pkg: NLAG, DATA_W, ACC_W, LAG_W, the state enum (IDLE/ACC/CLEAR), and the saturation constant ACC_MAX.
- Sub-module corr_acc_ram: simple dual-port NLAG×ACC_W block RAM, mapped to M9K.
  - Port A: synchronous read/write for the pipeline.
  - Port B: synchronous read for the host.
  - Zero initial contents.

## Test plan
- Clear, then one burst with x_cur=3 and all x_lag=2 → acc[k]=6 for all k; frame_cnt=1; burst_done high exactly at s+258.
- Clear, then x_cur=1 with x_lag=k (ramp), repeated over 3 bursts → acc[k]=3k; acc[255]=765.
- ACC_W=16, x_cur=255, x_lag=255, 2 bursts → acc[k]=65535 (65025+65025 saturates); sat=1.
- sync_in asserted at lag 100 of a burst → overrun=1, burst length unchanged, acc reflects one burst only; clr then clears overrun.
- clr pulsed mid-burst → burst completes first, then clear; clr_done at burst_done+NLAG+1; all rd_data read back 0.
- rst_n low at lag 50 → outputs 0 immediately, no writes after reset; a following clr plus one burst produces correct sums.
